motion_mask_gen: RTL and testbench

- Streaming producer of the per-pixel blend mask consumed by neural_core.
- Computes |pixel_t − pixel_t1|, applies a threshold and gain, and saturates the result to 8 bits.
- Emits the mask aligned with both source pixels under a valid/ready handshake, so neural_core can blend them downstream.
- Mask 255 = full motion (select pixel_t); mask 0 = static (select pixel_t1).

---
 rtl/motion_mask_gen.sv | 146 ++++++++++++++
 tb/tb_motion_mask_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_mask_gen.sv
// rtl/motion_mask_gen.sv - three-stage |pt - pt1| threshold/gain blend-mask producer
// Optional S2 hysteresis flag enabled by defining MASK_HYST_EN.
module motion_mask_gen #(
   parameter int PIX_W     = 8,
   parameter int GAIN_FRAC = 4,
   parameter int FCNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PIX_W-1:0]  cfg_thresh,
   input  logic [7:0]        cfg_gain,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  in_pixel_t,
   input  logic [PIX_W-1:0]  in_pixel_t1,
   input  logic              in_sof,
   input  logic              in_eol,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pixel_t,
   output logic [PIX_W-1:0]  out_pixel_t1,
   output logic [PIX_W-1:0]  out_mask,
   output logic              out_sof,
   output logic              out_eol,
   output logic [FCNT_W-1:0] frame_cnt
);
   localparam int PROD_W = PIX_W + 8;

   logic              en, accept;
   logic [PIX_W-1:0]  act_thresh;
   logic [7:0]        act_gain;

   logic              s1_valid, s1_sof, s1_eol;
   logic [PIX_W-1:0]  s1_pt, s1_pt1, s1_diff, s1_thresh;
   logic [7:0]        s1_gain;

   logic              s2_valid, s2_sof, s2_eol;
   logic [PIX_W-1:0]  s2_pt, s2_pt1;
   logic [PROD_W-1:0] s2_prod;

   logic              s3_valid;

   logic [PIX_W-1:0]  in_diff, eff_thresh, excess;
   logic [PROD_W-1:0] scaled;
   logic [PIX_W-1:0]  sat_mask;
   logic              use_half;

   assign en       = !s3_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;
   assign in_diff  = (in_pixel_t >= in_pixel_t1) ? (in_pixel_t - in_pixel_t1)
                                                 : (in_pixel_t1 - in_pixel_t);

   // Each beat carries its own thresh/gain so a SOF never retunes older in-flight beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_thresh <= '0;
         act_gain   <= 8'h10;
         frame_cnt  <= '0;
         s1_valid   <= 1'b0;
         s1_sof     <= 1'b0;
         s1_eol     <= 1'b0;
         s1_pt      <= '0;
         s1_pt1     <= '0;
         s1_diff    <= '0;
         s1_thresh  <= '0;
         s1_gain    <= 8'h10;
      end else if (en) begin
         if (accept && in_sof) begin
            act_thresh <= cfg_thresh;
            act_gain   <= cfg_gain;
            frame_cnt  <= frame_cnt + 1'b1;
         end
         s1_valid  <= in_valid;
         s1_sof    <= in_sof;
         s1_eol    <= in_eol;
         s1_pt     <= in_pixel_t;
         s1_pt1    <= in_pixel_t1;
         s1_diff   <= in_diff;
         s1_thresh <= in_sof ? cfg_thresh : act_thresh;
         s1_gain   <= in_sof ? cfg_gain : act_gain;
      end
   end

`ifdef MASK_HYST_EN
   logic hyst;

   // Halved threshold follows a moving pixel, never across a line or frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hyst <= 1'b0;
      end else if (en && s1_valid) begin
         hyst <= (excess != '0) && !s1_eol;
      end
   end

   assign use_half = hyst && !s1_sof;
`else
   assign use_half = 1'b0;
`endif

   assign eff_thresh = use_half ? (s1_thresh >> 1) : s1_thresh;
   assign excess     = (s1_diff > eff_thresh) ? (s1_diff - eff_thresh) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_eol   <= 1'b0;
         s2_pt    <= '0;
         s2_pt1   <= '0;
         s2_prod  <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_eol   <= s1_eol;
         s2_pt    <= s1_pt;
         s2_pt1   <= s1_pt1;
         s2_prod  <= PROD_W'(excess) * PROD_W'(s1_gain);
      end
   end

   assign scaled   = s2_prod >> GAIN_FRAC;
   assign sat_mask = (|scaled[PROD_W-1:PIX_W]) ? {PIX_W{1'b1}} : scaled[PIX_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid     <= 1'b0;
         out_sof      <= 1'b0;
         out_eol      <= 1'b0;
         out_pixel_t  <= '0;
         out_pixel_t1 <= '0;
         out_mask     <= '0;
      end else if (en) begin
         s3_valid     <= s2_valid;
         out_sof      <= s2_sof;
         out_eol      <= s2_eol;
         out_pixel_t  <= s2_pt;
         out_pixel_t1 <= s2_pt1;
         out_mask     <= sat_mask;
      end
   end

   assign out_valid = s3_valid;

endmodule

// File: tb/tb_motion_mask_gen.sv
// tb/tb_motion_mask_gen.sv - randomized and directed bench for motion_mask_gen with a beat-level model
module tb_motion_mask_gen;
   localparam int PIX_W  = 8;
   localparam int FCNT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [PIX_W-1:0]  cfg_thresh;
   logic [7:0]        cfg_gain;
   logic              in_valid, in_ready;
   logic [PIX_W-1:0]  in_pixel_t, in_pixel_t1;
   logic              in_sof, in_eol;
   logic              out_valid, out_ready;
   logic [PIX_W-1:0]  out_pixel_t, out_pixel_t1, out_mask;
   logic              out_sof, out_eol;
   logic [FCNT_W-1:0] frame_cnt;

   always #5 clk = ~clk;

   motion_mask_gen #(.PIX_W(PIX_W), .GAIN_FRAC(4), .FCNT_W(FCNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_thresh(cfg_thresh), .cfg_gain(cfg_gain),
      .in_valid(in_valid), .in_ready(in_ready), .in_pixel_t(in_pixel_t),
      .in_pixel_t1(in_pixel_t1), .in_sof(in_sof), .in_eol(in_eol),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel_t(out_pixel_t),
      .out_pixel_t1(out_pixel_t1), .out_mask(out_mask), .out_sof(out_sof),
      .out_eol(out_eol), .frame_cnt(frame_cnt)
   );

   typedef struct {
      logic [7:0] pt;
      logic [7:0] pt1;
      logic       sof;
      logic       eol;
      logic [7:0] mask;
   } beat_t;

   beat_t      exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         m_th, m_gain, m_fcnt;
   bit         m_hyst;
   bit         rand_ordy;
   logic [7:0] last_mask;
   logic       last_sof, last_eol;
   bit         saw_ready_low;
   int         pops = 0;
   bit         stall;
   logic [25:0] held;

   function automatic int calc_mask(int d, int th, int g);
      int ex, s;
      ex = (d > th) ? d - th : 0;
      s  = (ex * g) / 16;
      return (s > 255) ? 255 : s;
   endfunction

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_th = 0; m_gain = 16; m_fcnt = 0; m_hyst = 0;
   endtask

   // Called at posedge+2; judges acceptance for the coming edge and returns at the next posedge+2.
   task automatic step(bit v, logic [7:0] pt, logic [7:0] pt1, bit sof, bit eol, bit ordy,
                       output bit acc);
      beat_t b;
      int    d, th;
      in_valid = v; in_pixel_t = pt; in_pixel_t1 = pt1; in_sof = sof; in_eol = eol;
      out_ready = ordy;
      #1;
      acc = v && in_ready && !rst;
      if (acc) begin
         if (sof) begin
            m_th = int'(cfg_thresh); m_gain = int'(cfg_gain);
            m_fcnt = (m_fcnt + 1) % 65536;
         end
         d  = (pt > pt1) ? int'(pt) - int'(pt1) : int'(pt1) - int'(pt);
         th = m_th;
`ifdef MASK_HYST_EN
         if (m_hyst && !sof) th = th / 2;
         m_hyst = (d > th) && !eol;
`endif
         b.pt = pt; b.pt1 = pt1; b.sof = sof; b.eol = eol;
         b.mask = 8'(calc_mask(d, th, m_gain));
         exp_q.push_back(b);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic send(logic [7:0] pt, logic [7:0] pt1, bit sof, bit eol);
      bit acc = 0;
      int n = 0;
      while (!acc && n < 100) begin
         step(1'b1, pt, pt1, sof, eol, rand_ordy ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         tests++; fails++;
         $display("FAIL send_timeout: got no in_ready within %0d cycles required accept", n);
      end
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      check("frame_cnt", int'(frame_cnt), m_fcnt);
   endtask

   // Output scoreboard, sampled mid-cycle: what is seen here is what the next edge transfers.
   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
         if (!in_ready) saw_ready_low = 1'b1;
         if (stall)
            check("held_stable", int'({out_pixel_t, out_pixel_t1, out_mask, out_sof, out_eol}),
                  int'(held));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_beat: got mask %0d expected no beat", out_mask);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("out_beat", int'({out_pixel_t, out_pixel_t1, out_mask, out_sof, out_eol}),
                     int'({e.pt, e.pt1, e.mask, e.sof, e.eol}));
               last_mask = out_mask; last_sof = out_sof; last_eol = out_eol;
               pops++;
            end
         end
         stall = out_valid && !out_ready;
         held  = {out_pixel_t, out_pixel_t1, out_mask, out_sof, out_eol};
      end
   end

   initial begin
      bit acc;
      int sent, p0;
      rst = 1'b1; cfg_thresh = '0; cfg_gain = 8'h10; in_valid = 0; in_pixel_t = 0;
      in_pixel_t1 = 0; in_sof = 0; in_eol = 0; out_ready = 1; rand_ordy = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #2;

      // Basic mask plus latency
      cfg_thresh = 8'd10; cfg_gain = 8'h10;
      send(8'd100, 8'd200, 1'b1, 1'b0);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
      check("lat_not_yet", int'(out_valid), 0);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
      check("lat_3", int'(out_valid), 1);
      drain();
      check("basic_mask", int'(last_mask), 90);
      check("basic_sof", int'(last_sof), 1);
      check("basic_fcnt", int'(frame_cnt), 1);

      // Saturation and sub-threshold
      cfg_gain = 8'h40;
      send(8'd100, 8'd200, 1'b1, 1'b0);
      drain();
      check("sat_mask", int'(last_mask), 255);
      send(8'd100, 8'd95, 1'b0, 1'b0);
      drain();
      check("below_thresh", int'(last_mask), 0);

      // thresh 255, gain 0, one-pixel line
      cfg_thresh = 8'd255; cfg_gain = 8'hff;
      send(8'd255, 8'd0, 1'b1, 1'b1);
      drain();
      check("thresh255", int'(last_mask), 0);
      check("one_pix_flags", int'({last_sof, last_eol}), 3);
      cfg_thresh = 8'd0; cfg_gain = 8'h00;
      send(8'd0, 8'd255, 1'b1, 1'b0);
      drain();
      check("gain0", int'(last_mask), 0);

      // Stall mid-stream
      cfg_thresh = 8'd10; cfg_gain = 8'h10;
      send(8'd0, 8'd0, 1'b1, 1'b0);
      drain();
      saw_ready_low = 0; sent = 0; p0 = pops;
      for (int c = 0; c < 40 && sent < 8; c++) begin
         step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, sent == 7,
              !(c >= 3 && c < 7), acc);
         if (acc) sent++;
      end
      in_valid = 1'b0;
      drain();
      check("stall_ready_low", int'(saw_ready_low), 1);
      check("stall_count", pops - p0, 8);

      // Mid-frame gain change only applies from next SOF
      cfg_thresh = 8'd0; cfg_gain = 8'h10;
      send(8'd50, 8'd40, 1'b1, 1'b0);
      drain();
      check("gain_before", int'(last_mask), 10);
      cfg_gain = 8'h20;
      send(8'd50, 8'd40, 1'b0, 1'b0);
      drain();
      check("gain_ignored", int'(last_mask), 10);
      send(8'd50, 8'd40, 1'b1, 1'b0);
      drain();
      check("gain_doubled", int'(last_mask), 20);

      // Reset with three beats in flight
      send(8'd9, 8'd1, 1'b0, 1'b0);
      send(8'd8, 8'd2, 1'b0, 1'b0);
      send(8'd7, 8'd3, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_fcnt", int'(frame_cnt), 0);
      model_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      cfg_thresh = 8'd10; cfg_gain = 8'h10;
      send(8'd100, 8'd200, 1'b1, 1'b0);
      drain();
      check("restart_mask", int'(last_mask), 90);
      check("restart_fcnt", int'(frame_cnt), 1);

      // Randomized traffic with backpressure and config churn
      rand_ordy = 1;
      for (int i = 0; i < 400; i++) begin
         cfg_thresh = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 40));
         cfg_gain   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0)
            step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, $urandom_range(0, 1) == 1, acc);
         else
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
      end
      rand_ordy = 0;
      drain();

      // Hysteresis line pattern
      cfg_thresh = 8'd20; cfg_gain = 8'h10;
      send(8'd50, 8'd20, 1'b1, 1'b0);
      drain();
`ifdef MASK_HYST_EN
      check("hyst_m0", int'(last_mask), 10);
`endif
      send(8'd35, 8'd20, 1'b0, 1'b0);
      drain();
`ifdef MASK_HYST_EN
      check("hyst_m1", int'(last_mask), 5);
`endif
      send(8'd35, 8'd20, 1'b0, 1'b1);
      drain();
`ifdef MASK_HYST_EN
      check("hyst_m2", int'(last_mask), 5);
`endif
      send(8'd35, 8'd20, 1'b0, 1'b0);
      drain();
      check("hyst_m3", int'(last_mask), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
